aes_cbc_seq: RTL
================

// Module: aes_cbc_seq
// PURPOSE
//  Initiator-side sequencer that drives the iterative aes_core_gen (start/done interface) over a stream of
//  128-bit blocks. Holds config, feeds core_data_in, waits for core_done, captures core_data_out, applies
//  CBC chaining and returns results on a valid/ready output stream. Sits between the host/bus and the core.
// PARAMETERS
//  DONE_TIMEOUT  64  max cycles in RUN without core_done before err (must be >= 16)
//  TO_W          7   width of timeout counter (covers DONE_TIMEOUT)
// PORTS
//  clk          in   1    clock, all logic rising-edge
//  reset        in   1    synchronous, active-low reset
//  cfg_valid    in   1    config offer; accepted when cfg_valid & cfg_ready
//  cfg_ready    out  1    1 only in IDLE
//  cfg_enc_dec  in   1    1 = decipher, 0 = encipher
//  cfg_mode     in   2    00/01/10 = AES-128/192/256
//  cfg_key      in   256  key, forwarded unmodified to core_key
//  cfg_iv       in   128  initial chaining value
//  in_valid     in   1    input block offer
//  in_ready     out  1    1 only in READY
//  in_data      in   128  plaintext (enc) or ciphertext (dec)
//  in_last      in   1    marks final block of message
//  out_valid    out  1    result available; held until out_ready
//  out_ready    in   1    sink accepts result
//  out_data     out  128  result block
//  out_last     out  1    copy of in_last for this block
//  core_start   out  1    one-cycle start pulse to core
//  core_enc_dec out  1    registered cfg_enc_dec
//  core_mode    out  2    registered cfg_mode
//  core_key     out  256  registered cfg_key
//  core_data_in out  128  block to core; stable from LOAD through done
//  core_data_out in  128  core result
//  core_done    in   1    core completion; result valid this cycle
//  busy         out  1    state != IDLE
//  err          out  1    sticky timeout flag; cleared on next cfg accept
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE; all outputs 0 except cfg_ready=1; chain, timeout, err cleared. Applies
//   mid-operation too: in-flight block dropped, no out_valid produced; core result ignored.
//  FSM: IDLE -cfg accept-> READY -in accept-> LOAD -> RUN -core_done-> OUT -out accept-> READY, or IDLE if out_last.
//   RUN -timeout==DONE_TIMEOUT-> IDLE with err=1.
//  IDLE: cfg latched (enc_dec, mode, key, chain<=cfg_iv). cfg ignored in every other state.
//  READY: in_ready=1; accept latches in_data to blk, in_last to last_r.
//  LOAD (1 cycle): core_start=1. core_data_in = enc ? blk^chain : blk (registered, held through RUN).
//  RUN: core_start=0; timeout counts from 0, +1/cycle; core_done sampled; on done capture:
//   enc: res=core_data_out; chain<=core_data_out.  dec: res=core_data_out^chain; chain<=blk.
//  OUT: out_valid=1, out_data=res, out_last=last_r; stable until out_ready. core_done ignored outside RUN.
//  Latency: in accept at cycle N -> core_start at N+1; core_done at D -> out_valid at D+1.
//  Throughput: one block in flight; no in_ready while RUN/OUT (no input/output overlap).
//  Message end: chain only reset from cfg_iv; a new message requires return to IDLE and new cfg.
//  Simultaneous: core_done on same cycle as timeout hit -> done wins, no err.
// CONFIGURATION
//  AES_SEQ_ECB_EN defined: adds input port cfg_ecb (1 bit, latched with cfg); when 1, chaining disabled:
//   core_data_in=blk, res=core_data_out, chain unused. cfg_ecb=0 behaves exactly as CBC.
//  Not defined: no cfg_ecb port; CBC always.
// TESTING
//  1 CBC-128 enc, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102..0f, P1 6bc1bee22e409f96e93d7e117393172a,
//    P2 ae2d8a571e03ac9c9eb76fac45af8e51 (last) -> 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2, out_last on 2nd, then IDLE.
//  2 CBC-128 dec, same key/IV, inputs = outputs of 1 -> P1, P2 recovered; chain taken from ciphertext input.
//  3 out_ready low 20 cycles in OUT -> out_data/out_valid stable, in_ready=0, core_start not re-pulsed.
//  4 Core model never asserts done -> err=1 exactly DONE_TIMEOUT cycles after entering RUN; state IDLE; next cfg accept clears err.
//  5 reset=0 for 1 cycle during RUN -> all outputs 0 next cycle, cfg_ready=1, late core_done gives no out_valid.
//  6 AES_SEQ_ECB_EN, cfg_ecb=1, FIPS-197 key 000102..0f, P 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a for any IV.

Source files
------------

// File: rtl/aes_cbc_seq.sv
// Sequencer that drives an iterative start/done AES core over a block stream with CBC chaining.
// Optional build macro AES_SEQ_ECB_EN adds a cfg_ecb input that bypasses chaining per message.
module aes_cbc_seq #(
  parameter int unsigned DONE_TIMEOUT = 64,
  parameter int unsigned TO_W         = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_enc_dec,
  input  logic [1:0]   cfg_mode,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_iv,
`ifdef AES_SEQ_ECB_EN
  input  logic         cfg_ecb,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         core_start,
  output logic         core_enc_dec,
  output logic [1:0]   core_mode,
  output logic [255:0] core_key,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  input  logic         core_done,
  output logic         busy,
  output logic         err
);

  localparam int unsigned BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [BLK_W-1:0]  chain;
  logic [BLK_W-1:0]  blk;
  logic [BLK_W-1:0]  res;
  logic              last_r;
  logic              ecb;
  logic [TO_W-1:0]   timeout;
  logic              to_hit;

`ifdef AES_SEQ_ECB_EN
  logic ecb_r;
  assign ecb = ecb_r;
`else
  assign ecb = 1'b0;
`endif

  // RUN is abandoned on the edge where the counter reaches DONE_TIMEOUT
  assign to_hit = (timeout == TO_W'(DONE_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; core_done beats a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = READY;
      READY:   if (in_valid)  state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (core_done)   state_nxt = OUT;
        else if (to_hit) state_nxt = IDLE;
      end
      OUT:     if (out_ready) state_nxt = last_r ? IDLE : READY;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    cfg_ready  = 1'b1;
      READY:   in_ready   = 1'b1;
      LOAD:    core_start = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        out_last  = last_r;
      end
      default: ;
    endcase
  end

  assign out_data = res;

  // Config capture, block capture, chaining and timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      core_enc_dec <= 1'b0;
      core_mode    <= '0;
      core_key     <= '0;
      core_data_in <= '0;
      chain        <= '0;
      blk          <= '0;
      res          <= '0;
      last_r       <= 1'b0;
      timeout      <= '0;
      err          <= 1'b0;
`ifdef AES_SEQ_ECB_EN
      ecb_r        <= 1'b0;
`endif
    end else begin
      if (state == IDLE && cfg_valid) begin
        core_enc_dec <= cfg_enc_dec;
        core_mode    <= cfg_mode;
        core_key     <= cfg_key;
        chain        <= cfg_iv;
        err          <= 1'b0;
`ifdef AES_SEQ_ECB_EN
        ecb_r        <= cfg_ecb;
`endif
      end
      if (state == READY && in_valid) begin
        blk          <= in_data;
        last_r       <= in_last;
        core_data_in <= (!core_enc_dec && !ecb) ? (in_data ^ chain) : in_data;
      end
      if (state == LOAD) timeout <= '0;
      if (state == RUN) begin
        timeout <= timeout + TO_W'(1);
        if (core_done) begin
          if (core_enc_dec && !ecb) begin
            res   <= core_data_out ^ chain;
            chain <= blk;
          end else begin
            res   <= core_data_out;
            chain <= core_data_out;
          end
        end else if (to_hit) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
